// File: rtl/demux_sched_pkg.sv
// Shared constants, FSM state type and select decode for the 1x8 demux scheduler.
package demux_sched_pkg;

  localparam int NCH  = 8;
  localparam int SELW = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Decode a channel index into the one-hot valid vector driven toward the demux tree.
  function automatic logic [NCH-1:0] idx_to_onehot(input logic [SELW-1:0] idx);
    idx_to_onehot = {{(NCH-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/demux_rr_pick.sv
// Rotate-priority find-first: the first set mask bit at or above ptr, wrapping 7 -> 0.
module demux_rr_pick
  import demux_sched_pkg::*;
(
  input  logic [NCH-1:0]  mask,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] idx,
  output logic            found
);

  logic [SELW-1:0] cand_s;

  // Scan from the farthest offset down to offset 0 so the nearest enabled channel wins last.
  always_comb begin
    idx    = ptr;
    found  = 1'b0;
    cand_s = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      cand_s = ptr + SELW'(i);
      idx    = mask[cand_s] ? cand_s : idx;
      found  = found | mask[cand_s];
    end
  end

endmodule

// File: rtl/demux_1x8_sched.sv
// Stream scheduler: routes each accepted word to one of 8 channels (round-robin or addressed).
module demux_1x8_sched
  import demux_sched_pkg::*;
#(
  parameter int DW = 8
)(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  input  logic [SELW-1:0] in_dest,
  input  logic            mode,
  input  logic [NCH-1:0]  ch_en,
  output logic [SELW-1:0] sel,
  output logic [NCH-1:0]  out_valid,
  output logic [DW-1:0]   out_data,
  input  logic [NCH-1:0]  out_ready,
  output logic            busy,
  output logic [7:0]      drop_cnt
);

  state_e          state_q, state_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [DW-1:0]   data_q, data_d;
  logic [NCH-1:0]  valid_q, valid_d;
  logic [SELW-1:0] rr_q, rr_d;
  logic [7:0]      drop_q, drop_d;

  logic [SELW-1:0] ptr_s;
  logic [SELW-1:0] pick_idx_s;
  logic            pick_found_s;
  logic [SELW-1:0] dest_s;
  logic            complete_s;
  logic            in_ready_s;
  logic            accept_s;
  logic            deliver_s;
  logic            drop_s;

  // A word accepted during a completion must search from just past the channel being released.
  always_comb begin
    if (state_q == SEND) begin
      ptr_s = sel_q + 3'd1;
    end else begin
      ptr_s = rr_q;
    end
  end

  demux_rr_pick u_pick (
    .mask  (ch_en),
    .ptr   (ptr_s),
    .idx   (pick_idx_s),
    .found (pick_found_s)
  );

  // Handshake decode: destination choice, completion, accept and drop qualification.
  always_comb begin
    if (mode) begin
      dest_s = in_dest;
    end else begin
      dest_s = pick_idx_s;
    end
    complete_s = (state_q == SEND) && out_ready[sel_q];
    in_ready_s = ((state_q == IDLE) || complete_s) && !(!mode && !pick_found_s);
    accept_s   = in_valid && in_ready_s;
    deliver_s  = accept_s && ch_en[dest_s];
    drop_s     = accept_s && !ch_en[dest_s];
  end

  // Next-state: release the held word on completion, then load a new one if delivered.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    data_d  = data_q;
    valid_d = valid_q;
    rr_d    = rr_q;
    drop_d  = drop_q;
    case (state_q)
      IDLE: begin
        state_d = IDLE;
      end
      SEND: begin
        if (complete_s) begin
          state_d = IDLE;
          valid_d = '0;
          if (!mode) begin
            rr_d = sel_q + 3'd1;
          end else begin
            rr_d = rr_q;
          end
        end else begin
          state_d = SEND;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = '0;
      end
    endcase
    if (deliver_s) begin
      state_d = SEND;
      sel_d   = dest_s;
      data_d  = in_data;
      valid_d = idx_to_onehot(dest_s);
    end else begin
      sel_d   = sel_d;
    end
    if (drop_s && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end else begin
      drop_d = drop_q;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      data_q  <= '0;
      valid_q <= '0;
      rr_q    <= '0;
      drop_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      rr_q    <= rr_d;
      drop_q  <= drop_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign sel       = sel_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign busy      = (state_q == SEND);
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_demux_1x8_sched.sv
// Table-driven bench for demux_1x8_sched plus a drop-counter saturation sequence.
module tb_demux_1x8_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_dest;
  logic       mode;
  logic [7:0] ch_en;
  logic [2:0] sel;
  logic [7:0] out_valid;
  logic [7:0] out_data;
  logic [7:0] out_ready;
  logic       busy;
  logic [7:0] drop_cnt;

  always #5 clk = ~clk;

  demux_1x8_sched #(.DW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_dest   (in_dest),
    .mode      (mode),
    .ch_en     (ch_en),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy),
    .drop_cnt  (drop_cnt)
  );

  typedef struct {
    logic       rst;
    logic       iv;
    logic [7:0] data;
    logic [2:0] dest;
    logic       mode;
    logic [7:0] en;
    logic [7:0] ordy;
    logic       e_ir;
    logic [7:0] e_ov;
    logic [2:0] e_sel;
    logic [7:0] e_od;
    logic       e_busy;
    logic [7:0] e_drop;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic add(input logic r, input logic iv, input logic [7:0] d, input logic [2:0] dst,
                     input logic m, input logic [7:0] en, input logic [7:0] ordy,
                     input logic e_ir, input logic [7:0] e_ov, input logic [2:0] e_sel,
                     input logic [7:0] e_od, input logic e_busy, input logic [7:0] e_drop);
    vec_t v;
    v.rst = r; v.iv = iv; v.data = d; v.dest = dst; v.mode = m; v.en = en; v.ordy = ordy;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_sel = e_sel; v.e_od = e_od; v.e_busy = e_busy;
    v.e_drop = e_drop;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int row, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s (step %0d): got 0x%02h, expected 0x%02h", name, row, act, exp);
    end
  endtask

  initial begin
    logic ov_seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_dest   = 3'd0;
    mode      = 1'b0;
    ch_en     = 8'h00;
    out_ready = 8'h00;
    repeat (2) @(posedge clk);

    // reset state
    add(1'b0,1'b0,8'h00,3'd0,1'b0,8'hFF,8'hFF, 1'b1,8'h00,3'd0,8'h00,1'b0,8'd0);
    // round-robin over all channels, back-to-back
    for (int n = 0; n < 8; n++) begin
      if (n == 0) begin
        add(1'b0,1'b1,8'h10,3'd0,1'b0,8'hFF,8'hFF, 1'b1,8'h00,3'd0,8'h00,1'b0,8'd0);
      end else begin
        add(1'b0,1'b1,8'h10 + 8'(n),3'd0,1'b0,8'hFF,8'hFF,
            1'b1,8'h01 << (n-1),3'(n-1),8'h10 + 8'(n-1),1'b1,8'd0);
      end
    end
    add(1'b0,1'b0,8'h00,3'd0,1'b0,8'hFF,8'hFF, 1'b1,8'h80,3'd7,8'h17,1'b1,8'd0);
    add(1'b0,1'b0,8'h00,3'd0,1'b0,8'hFF,8'hFF, 1'b1,8'h00,3'd7,8'h17,1'b0,8'd0);
    // round-robin skipping disabled channels: 2,5,7,2
    add(1'b0,1'b1,8'h20,3'd0,1'b0,8'hA4,8'hFF, 1'b1,8'h00,3'd7,8'h17,1'b0,8'd0);
    add(1'b0,1'b1,8'h21,3'd0,1'b0,8'hA4,8'hFF, 1'b1,8'h04,3'd2,8'h20,1'b1,8'd0);
    add(1'b0,1'b1,8'h22,3'd0,1'b0,8'hA4,8'hFF, 1'b1,8'h20,3'd5,8'h21,1'b1,8'd0);
    add(1'b0,1'b1,8'h23,3'd0,1'b0,8'hA4,8'hFF, 1'b1,8'h80,3'd7,8'h22,1'b1,8'd0);
    add(1'b0,1'b0,8'h00,3'd0,1'b0,8'hA4,8'hFF, 1'b1,8'h04,3'd2,8'h23,1'b1,8'd0);
    // round-robin with nothing enabled: no accept, no drop
    add(1'b0,1'b1,8'h24,3'd0,1'b0,8'h00,8'hFF, 1'b0,8'h00,3'd2,8'h23,1'b0,8'd0);
    add(1'b0,1'b1,8'h24,3'd0,1'b0,8'h00,8'hFF, 1'b0,8'h00,3'd2,8'h23,1'b0,8'd0);
    // addressed 3,6,1 with ch6 disabled; the drop coincides with completion of ch3
    add(1'b0,1'b1,8'h30,3'd3,1'b1,8'h0F,8'hFF, 1'b1,8'h00,3'd2,8'h23,1'b0,8'd0);
    add(1'b0,1'b1,8'h31,3'd6,1'b1,8'h0F,8'hFF, 1'b1,8'h08,3'd3,8'h30,1'b1,8'd0);
    add(1'b0,1'b1,8'h32,3'd1,1'b1,8'h0F,8'hFF, 1'b1,8'h00,3'd3,8'h30,1'b0,8'd1);
    add(1'b0,1'b0,8'h00,3'd0,1'b1,8'h0F,8'hFF, 1'b1,8'h02,3'd1,8'h32,1'b1,8'd1);
    add(1'b0,1'b0,8'h00,3'd0,1'b1,8'h0F,8'hFF, 1'b1,8'h00,3'd1,8'h32,1'b0,8'd1);
    // backpressure on ch4 while ch3 is ready; release with a word waiting
    add(1'b0,1'b1,8'hAB,3'd4,1'b1,8'hFF,8'h08, 1'b1,8'h00,3'd1,8'h32,1'b0,8'd1);
    for (int k = 0; k < 5; k++) begin
      add(1'b0,1'b1,8'hCD,3'd2,1'b1,8'hFF,8'h08, 1'b0,8'h10,3'd4,8'hAB,1'b1,8'd1);
    end
    add(1'b0,1'b1,8'hCD,3'd2,1'b1,8'hFF,8'h18, 1'b1,8'h10,3'd4,8'hAB,1'b1,8'd1);
    add(1'b0,1'b0,8'h00,3'd0,1'b1,8'hFF,8'h00, 1'b0,8'h04,3'd2,8'hCD,1'b1,8'd1);
    // disable the held channel mid-SEND; word still delivered
    add(1'b0,1'b0,8'h00,3'd0,1'b1,8'hFB,8'h00, 1'b0,8'h04,3'd2,8'hCD,1'b1,8'd1);
    add(1'b0,1'b0,8'h00,3'd0,1'b1,8'hFB,8'h04, 1'b1,8'h04,3'd2,8'hCD,1'b1,8'd1);
    add(1'b0,1'b0,8'h00,3'd0,1'b1,8'hFB,8'h00, 1'b1,8'h00,3'd2,8'hCD,1'b0,8'd1);
    // reset while holding a word for ch5; next round-robin word goes to ch0
    add(1'b0,1'b1,8'h55,3'd5,1'b1,8'hFF,8'h00, 1'b1,8'h00,3'd2,8'hCD,1'b0,8'd1);
    add(1'b0,1'b0,8'h00,3'd0,1'b1,8'hFF,8'h00, 1'b0,8'h20,3'd5,8'h55,1'b1,8'd1);
    add(1'b1,1'b0,8'h00,3'd0,1'b1,8'hFF,8'h00, 1'b0,8'h20,3'd5,8'h55,1'b1,8'd1);
    add(1'b0,1'b1,8'h60,3'd0,1'b0,8'hFF,8'hFF, 1'b1,8'h00,3'd0,8'h00,1'b0,8'd0);
    add(1'b0,1'b0,8'h00,3'd0,1'b0,8'hFF,8'hFF, 1'b1,8'h01,3'd0,8'h60,1'b1,8'd0);
    add(1'b0,1'b0,8'h00,3'd0,1'b0,8'hFF,8'hFF, 1'b1,8'h00,3'd0,8'h60,1'b0,8'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst       = vecs[i].rst;
      in_valid  = vecs[i].iv;
      in_data   = vecs[i].data;
      in_dest   = vecs[i].dest;
      mode      = vecs[i].mode;
      ch_en     = vecs[i].en;
      out_ready = vecs[i].ordy;
      #1;
      chk("in_ready",  i, {7'd0, in_ready}, {7'd0, vecs[i].e_ir});
      chk("out_valid", i, out_valid,        vecs[i].e_ov);
      chk("sel",       i, {5'd0, sel},      {5'd0, vecs[i].e_sel});
      chk("out_data",  i, out_data,         vecs[i].e_od);
      chk("busy",      i, {7'd0, busy},     {7'd0, vecs[i].e_busy});
      chk("drop_cnt",  i, drop_cnt,         vecs[i].e_drop);
    end

    // 300 addressed words to disabled channels: counter saturates at 255
    ov_seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      rst       = 1'b0;
      mode      = 1'b1;
      ch_en     = 8'h00;
      out_ready = 8'hFF;
      in_valid  = 1'b1;
      in_dest   = 3'(i);
      in_data   = 8'(i);
      #1;
      ov_seen = ov_seen | (out_valid != 8'h00);
      if (i == 0)   chk("sat_in_ready", i, {7'd0, in_ready}, 8'h01);
      if (i == 100) chk("sat_drop_100", i, drop_cnt, 8'd100);
      if (i == 255) chk("sat_drop_255", i, drop_cnt, 8'd255);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("sat_drop_final", 300, drop_cnt, 8'd255);
    chk("sat_no_valid",   300, {7'd0, ov_seen}, 8'h00);
    chk("sat_idle",       300, {7'd0, busy}, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/demux_1x8_sched.md
Name: demux_1x8_sched

Overview:
- Stream scheduler that front-ends the structural 1x8 demultiplexer.
- Accepts one valid/ready input stream and routes each word to exactly one of 8 output channels, each with its own valid/ready handshake.
- Two routing modes: round-robin over enabled channels, or explicit destination carried with each word.
- Drives the 3-bit select for the demux tree and holds data until the chosen channel accepts it.

Parameters:
- DW, 8, data word width in bits.
- NCH, 8, channel count; fixed at 8 (select width 3); other values unsupported.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input word present.
- in_ready  output  1  scheduler can accept the input word this cycle.
- in_data  input  DW  input word.
- in_dest  input  3  destination channel; used only when mode=1.
- mode  input  1  0 = round-robin over ch_en, 1 = addressed by in_dest.
- ch_en  input  8  per-channel enable mask.
- sel  output  3  current demux select (destination of held word).
- out_valid  output  8  one-hot valid; bit k set means word pending for channel k.
- out_data  output  DW  held word, shared by all channels.
- out_ready  input  8  per-channel ready.
- busy  output  1  high while a word is held (state SEND).
- drop_cnt  output  8  saturating count of words dropped for disabled destinations.

Behaviour:
- Reset: state IDLE, out_valid=0, out_data=0, sel=0, rr pointer=0, drop_cnt=0, busy=0. Reset mid-SEND discards the held word and does not count it as a drop.
- FSM states: IDLE (nothing held) and SEND (word held, out_valid[sel]=1).
- Accept condition: in_valid & in_ready.
- in_ready = (IDLE | (SEND & out_ready[sel])) & ~(mode==0 & ch_en==0).
- Destination, computed combinationally at accept:
  - mode=0: first enabled channel at or after rr pointer, searching upward with wrap 7->0.
  - mode=1: in_dest.
- Accept with ch_en[dest]=1: register in_data into out_data and dest into sel; next state SEND. Latency is 1 cycle, so out_valid[dest] is high the cycle after accept.
- Accept in mode=1 with ch_en[in_dest]=0: word dropped, drop_cnt increments (saturates at 255), state unchanged by this word.
- In SEND, out_valid = one-hot(sel). out_data and sel are held stable until out_ready[sel]=1. Other channels' out_ready bits are ignored.
- Completion: out_ready[sel] in SEND completes the transfer.
  - mode=0 at completion: rr pointer <= sel+1 (mod 8).
  - If a new word is accepted the same cycle, stay in SEND with new data/sel (back-to-back, one word per cycle). Otherwise go to IDLE and clear out_valid.
- Simultaneous completion and dropped accept: go to IDLE and increment drop_cnt.
- mode and ch_en are sampled only at accept. Changes while in SEND do not affect the held word, which still completes even if its channel is disabled.
- mode=0 with ch_en=0: in_ready=0, no drop, pointer unchanged.
- busy = (state==SEND).
- No combinational path from out_ready to out_data or sel. in_ready does depend combinationally on out_ready[sel].

Decomposition:
- Package demux_sched_pkg holds:
  - NCH=8 and SELW=3 constants.
  - state enum {IDLE, SEND}.
  - a function mapping a 3-bit index to an 8-bit one-hot.
- Sub-module demux_rr_pick: combinational rotate-priority find-first. Inputs are an 8-bit mask and a 3-bit pointer; outputs are a 3-bit index and a found flag. Verified standalone.

Test Plan:
- Reset mid-SEND: hold a word for ch5 with out_ready=0, then assert rst for 1 cycle -> out_valid=0, busy=0, sel=0, drop_cnt=0; next RR word goes to ch0.
- RR basic: mode=0, ch_en=8'hFF, out_ready=8'hFF, words 0x10..0x17 back-to-back -> word n appears on channel n one cycle after accept; in_ready stays 1; pointer wraps to 0.
- RR skip: ch_en=8'b1010_0100, 4 words -> destinations 2,5,7,2 in order. With ch_en=0 -> in_ready=0 and drop_cnt unchanged.
- Addressed with drop: mode=1, ch_en=8'h0F, in_dest sequence 3,6,1 -> ch3 and ch1 receive their words; the word for 6 is dropped, drop_cnt=1, out_valid never sets bit 6.
- Backpressure: hold 0xAB for ch4 with out_ready[4]=0 for 5 cycles while out_ready[3]=1 -> out_data=0xAB, sel=4, in_ready=0 throughout; release out_ready[4] with in_valid high -> completion and next accept in the same cycle.
- Drop saturation: 300 dropped words in mode=1 -> drop_cnt=255. Mid-SEND clearing of ch_en[sel] -> held word still delivered.
